// File: rtl/lsu_mem_responder.sv
// Word-organised data-memory responder for the LSU with configurable wait states.
module lsu_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter              INIT_FILE   = "mem_init.hex"
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_adr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic        lsu_read_enable_i,
    input  logic        lsu_write_enable_i,
    output logic [31:0] lsu_dat_o,
    output logic        lsu_ack_o,
    output logic        lsu_err_o
);

    localparam int unsigned Words    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    logic [31:0]           mem [Words];

    logic [1:0]            state, state_next;
    logic [3:0]            count, count_next;
    logic [ADDR_WIDTH-1:0] idx_lat;
    logic [31:0]           dat_lat;
    logic [3:0]            sel_lat;
    logic                  wr_lat;
    logic                  err_lat;
    logic [31:0]           dat_out;
    logic                  ack, err;

    logic                  req, valid_now, enter_resp;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_dat;
    logic [3:0]            acc_sel;
    logic                  acc_wr, acc_err, do_write, do_read;

    logic unused_bits;
    assign unused_bits = ^{lsu_adr_i[1:0], INIT_FILE};

    assign req       = lsu_read_enable_i | lsu_write_enable_i;
    assign valid_now = (lsu_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2])
                       && (lsu_sel_i != 4'b0000);

    // With zero wait states RESP is entered on the request edge itself, so the
    // access must use the live inputs rather than the latched copy.
    always_comb begin
        if (state == StIdle) begin
            acc_idx = lsu_adr_i[ADDR_WIDTH+1:2];
            acc_dat = lsu_dat_i;
            acc_sel = lsu_sel_i;
            acc_wr  = lsu_write_enable_i;
            acc_err = ~valid_now;
        end else begin
            acc_idx = idx_lat;
            acc_dat = dat_lat;
            acc_sel = sel_lat;
            acc_wr  = wr_lat;
            acc_err = err_lat;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        enter_resp = 1'b0;
        case (state)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = StWait;
                        count_next = WaitLoad;
                    end
                end
            end
            StWait: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: state_next = req ? StHold : StIdle;
            StHold: if (!req) state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // Gating with rst_i keeps the unreset RAM from being written while reset is held.
    assign do_write = enter_resp & acc_wr & ~acc_err & rst_i;
    assign do_read  = enter_resp & ~acc_wr & ~acc_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= StIdle;
            count   <= 4'd0;
            idx_lat <= '0;
            dat_lat <= 32'd0;
            sel_lat <= 4'd0;
            wr_lat  <= 1'b0;
            err_lat <= 1'b0;
            dat_out <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            ack   <= enter_resp & ~acc_err;
            err   <= enter_resp & acc_err;
            if (state == StIdle && req) begin
                idx_lat <= lsu_adr_i[ADDR_WIDTH+1:2];
                dat_lat <= lsu_dat_i;
                sel_lat <= lsu_sel_i;
                wr_lat  <= lsu_write_enable_i;
                err_lat <= ~valid_now;
            end
            if (do_read) dat_out <= mem[acc_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
            end
        end
    end

    assign lsu_dat_o = dat_out;
    assign lsu_ack_o = ack;
    assign lsu_err_o = err;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: one instance with 1 wait state, one with 3.
module tb_lsu_mem_responder;

    typedef struct {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        re, we;
    int          dut_id;

    logic        a_re, a_we, b_re, b_we;
    logic [31:0] a_dat, b_dat;
    logic        a_ack, a_err, b_ack, b_err;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] last_rd [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign a_re = re & (dut_id == 0);
    assign a_we = we & (dut_id == 0);
    assign b_re = re & (dut_id == 1);
    assign b_we = we & (dut_id == 1);

    lsu_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .lsu_adr_i(adr), .lsu_dat_i(wdat), .lsu_sel_i(sel),
        .lsu_read_enable_i(a_re), .lsu_write_enable_i(a_we),
        .lsu_dat_o(a_dat), .lsu_ack_o(a_ack), .lsu_err_o(a_err)
    );

    lsu_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .lsu_adr_i(adr), .lsu_dat_i(wdat), .lsu_sel_i(sel),
        .lsu_read_enable_i(b_re), .lsu_write_enable_i(b_we),
        .lsu_dat_o(b_dat), .lsu_ack_o(b_ack), .lsu_err_o(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_one(input int id, input logic ack, input logic err,
                               input logic [31:0] dat);
        exp_t e;
        chk("ack_err_exclusive", {31'd0, ack & err}, 32'd0);
        if (id == 0 ? qa.size() == 0 : qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp dut%0d: got ack=%b err=%b expected none", id, ack, err);
        end else begin
            e = (id == 0) ? qa.pop_front() : qb.pop_front();
            chk("resp_kind", {30'd0, ack, err}, {30'd0, ~e.is_err, e.is_err});
            chk("resp_data", dat, e.dat);
        end
    endtask

    always @(negedge clk) begin
        if (a_ack || a_err) monitor_one(0, a_ack, a_err, a_dat);
        if (b_ack || b_err) monitor_one(1, b_ack, b_err, b_dat);
    end

    task automatic txn(input int id, input logic w, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic exp_err,
                       input logic [31:0] exp_rd, input int hold);
        exp_t e;
        int   n = 0;
        int   extra = 0;
        int   ws = (id == 0) ? 1 : 3;
        logic resp;
        e.is_err = exp_err;
        if (!exp_err && !w) last_rd[id] = exp_rd;
        e.dat = last_rd[id];
        if (id == 0) qa.push_back(e); else qb.push_back(e);
        dut_id = id; adr = a; sel = s; wdat = d; we = w; re = r;
        do begin
            @(posedge clk); #1;
            n++;
            resp = (id == 0) ? (a_ack | a_err) : (b_ack | b_err);
        end while (!resp && n < 20);
        chk("latency", n, ws + 1);
        repeat (hold) begin
            @(posedge clk); #1;
            if ((id == 0) ? (a_ack | a_err) : (b_ack | b_err)) extra++;
        end
        if (hold > 0) chk("hold_no_second_resp", extra, 0);
        we = 1'b0; re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        adr = 32'h0; wdat = 32'h0; sel = 4'hf; dut_id = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        // Reset held with requests active on both instances.
        we = 1'b1; re = 1'b1;
        repeat (3) begin
            dut_id = 0; @(posedge clk); #1;
            dut_id = 1; @(posedge clk); #1;
        end
        chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_a_err", {31'd0, a_err}, 32'd0);
        chk("rst_a_dat", a_dat, 32'd0);
        chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
        chk("rst_b_dat", b_dat, 32'd0);
        we = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Instance A, one wait state.
        txn(0, 1, 0, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 0);
        txn(0, 0, 1, 32'h10, 4'b1111, 32'h0, 0, 32'hDEADBEEF, 0);
        txn(0, 1, 0, 32'h10, 4'b0100, 32'h00AA0000, 0, 32'h0, 0);
        txn(0, 0, 1, 32'h10, 4'b1111, 32'h0, 0, 32'hDEAABEEF, 0);
        txn(0, 1, 0, 32'h0, 4'b1111, 32'h11111111, 0, 32'h0, 0);
        txn(0, 1, 0, 32'h1000, 4'b1111, 32'h99999999, 1, 32'h0, 0);
        txn(0, 0, 1, 32'h0, 4'b1111, 32'h0, 0, 32'h11111111, 0);
        txn(0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'h0, 0);
        txn(0, 0, 1, 32'h10, 4'b1111, 32'h0, 0, 32'hDEAABEEF, 4);
        txn(0, 0, 1, 32'h0, 4'b1111, 32'h0, 0, 32'h11111111, 0);
        // Both enables high: the write wins.
        txn(0, 1, 1, 32'h0, 4'b1111, 32'h22222222, 0, 32'h0, 0);
        txn(0, 0, 1, 32'h0, 4'b1111, 32'h0, 0, 32'h22222222, 0);
        txn(0, 1, 0, 32'h14, 4'b0011, 32'hBEEF5A5A, 0, 32'h0, 0);
        txn(0, 1, 0, 32'h14, 4'b1100, 32'h1234BEEF, 0, 32'h0, 0);
        txn(0, 0, 1, 32'h14, 4'b1111, 32'h0, 0, 32'h12345A5A, 0);

        // Instance B, three wait states, reset during WAIT aborts the write.
        txn(1, 1, 0, 32'h20, 4'b1111, 32'hCAFEF00D, 0, 32'h0, 0);
        txn(1, 0, 1, 32'h20, 4'b1111, 32'h0, 0, 32'hCAFEF00D, 0);
        dut_id = 1; adr = 32'h20; sel = 4'hf; wdat = 32'h12345678; we = 1'b1; re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        we = 1'b0;
        last_rd[1] = 32'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("midwait_rst_ack", {31'd0, b_ack}, 32'd0);
        chk("midwait_rst_dat", b_dat, 32'd0);
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        txn(1, 0, 1, 32'h20, 4'b1111, 32'h0, 0, 32'hCAFEF00D, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
